id_pipe: RTL and testbench
==========================

# id_pipe

Parametrised, pipelined instruction-decode stage for the MIPS core. Decodes one instruction per cycle, reads two operands from an internal XLEN-wide register file with write-back bypass, generates the extended immediate and write-enable/destination, and presents the result to EX through a registered valid/ready stage. It adds load-use stall detection, flush, and held-operand refresh.

## Interface

- XLEN, 32: register and datapath width (32 or 64).
- ZERO_R0, 1: 1 = register 0 reads as zero and ignores writes; 0 = ordinary register.
- LOGIC_ZEXT, 1: 1 = ANDI/ORI/XORI immediates zero-extended; 0 = sign-extended (legacy mode).

- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered by IF.
- in_ready  out  1  stage accepts instruction this cycle.
- in_ins  in  32  instruction word.
- flush  in  1  discard held instruction (branch redirect).
- wb_we  in  1  write-back enable.
- wb_adr  in  5  write-back register address.
- wb_data  in  XLEN  write-back data.
- out_valid  out  1  decoded instruction valid for EX.
- out_ready  in  1  EX accepts.
- out_ins  out  32  held instruction word.
- out_rdata1  out  XLEN  operand at Ins[25:21].
- out_rdata2  out  XLEN  operand at Ins[20:16].
- out_imm  out  XLEN  extended immediate.
- out_wadr  out  5  destination register.
- out_we  out  1  instruction writes the register file.

## Operation

- Fields: op=Ins[31:26], func=Ins[5:0], rs=Ins[25:21], rt=Ins[20:16], rd=Ins[15:11]; opcode/func constants from common_param.vh.
- Destination: JAL → 31; R_FORM or JALR → rd; otherwise rt.
- out_we: R_FORM with func not in {JR, MTHI, MTLO, MULT, DIV, DIVU}; op 8..15; LW; JAL. Else 0.
- Immediate: sign-extend Ins[15:0] to XLEN for ADDI, ADDIU, SLTI, SLTIU, LW, SW, BEQ, BNE; ANDI/ORI/XORI sign-extend only when LOGIC_ZEXT=0; all others zero-extend.
- Register file: 32 × XLEN; written on rising edge when wb_we (address 0 ignored when ZERO_R0=1).
- Read bypass: a read of address equal to wb_adr with wb_we=1 returns wb_data in the same cycle (not for address 0 when ZERO_R0=1).
- Load-use stall: stall=1 when out_valid, held instruction is LW, out_wadr≠0, and out_wadr equals rs or rt of in_ins.
- in_ready = (out_ready | ~out_valid) & ~stall & ~flush.
- Advance (out_ready | ~out_valid): if in_valid & in_ready load all out_* and set out_valid=1; if stall, out_valid←0 (bubble); otherwise out_valid←0.
- Hold (out_valid & ~out_ready): out_* hold, except out_rdata1/2 refresh from wb_data when wb_we and wb_adr matches held rs/rt.
- flush: out_valid←0 next edge, in_ins not accepted; flush overrides stall and hold.

## Timing

- Reset (RST=0, asynchronous): out_valid=0, all out_* =0, all 32 registers =0; in_ready=0 while in reset.
- Latency: accept at edge N → out_valid with decoded data after edge N.
- Throughput: 1 instruction/cycle with out_ready=1 and no hazards.
- Stall costs exactly one bubble; in_ready is combinational from out_valid, out_ready, stall, flush.
- Write-back and read of same register in one cycle: new data captured (bypass).
- Reset asserted mid-transfer: held instruction lost; no partial state remains.

## Test plan

- Reset then ADDI r1,r0,-1 (0x2001FFFF) → next cycle out_imm=0xFFFFFFFF, out_wadr=1, out_we=1, out_rdata1=0.
- ORI r2,r0,0x8000 with LOGIC_ZEXT=1 → out_imm=0x00008000; LOGIC_ZEXT=0 → 0xFFFF8000.
- wb_we=1, wb_adr=3, wb_data=0x12345678 same cycle as ADD r4,r3,r3 accepted → out_rdata1=out_rdata2=0x12345678.
- LW r5,0(r0) then ADD r6,r5,r5 back-to-back, out_ready=1 → in_ready=0 one cycle, one bubble (out_valid=0), ADD emerges next cycle.
- Hold ADD r7,r8,r0 with out_ready=0, write r8=0xAA → out_rdata1 becomes 0xAA while out_valid stays 1; JAL → out_wadr=31; JR → out_we=0.
- flush with valid held instruction and in_valid=1 → out_valid=0 next cycle, input not consumed; ZERO_R0=1 write r0=5 → later read of r0 returns 0.

Source files
------------

// File: rtl/id_pipe_if.sv
// Decode-stage bus: IF-side handshake, write-back port and EX-side
// valid/ready result. The decode stage takes the slave view.
interface id_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_ins;
    logic            flush;
    logic            wb_we;
    logic [4:0]      wb_adr;
    logic [XLEN-1:0] wb_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_ins;
    logic [XLEN-1:0] out_rdata1;
    logic [XLEN-1:0] out_rdata2;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_wadr;
    logic            out_we;

    modport master (
        output in_valid, in_ins, flush, wb_we, wb_adr, wb_data, out_ready,
        input  in_ready, out_valid, out_ins, out_rdata1, out_rdata2,
               out_imm, out_wadr, out_we
    );

    modport slave (
        input  in_valid, in_ins, flush, wb_we, wb_adr, wb_data, out_ready,
        output in_ready, out_valid, out_ins, out_rdata1, out_rdata2,
               out_imm, out_wadr, out_we
    );
endinterface

// File: rtl/id_pipe.sv
// MIPS instruction-decode stage: field decode, 32-entry register file
// with write-back bypass, immediate extension, load-use stall, flush and
// a registered valid/ready output slot whose operands track write-back
// while EX is not accepting.
module id_pipe #(
    parameter int XLEN       = 32,
    parameter int ZERO_R0    = 1,
    parameter int LOGIC_ZEXT = 1
) (
    input  logic     CLK,
    input  logic     RST,
    id_pipe_if.slave bus
);
    localparam logic [5:0] OP_RFORM = 6'd0;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_JR    = 6'd8;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    // Register 0 is hard-wired to zero only when ZERO_R0 is set.
    function automatic logic zero_reg(input logic [4:0] adr);
        return (ZERO_R0 != 0) && (adr == 5'd0);
    endfunction

    // Arithmetic, memory and branch offsets are signed; logical immediates
    // follow LOGIC_ZEXT; everything else (LUI, jumps, R-form) zero-extends.
    function automatic logic [XLEN-1:0] ext_imm(input logic [5:0] op,
                                                 input logic [15:0] imm16);
        logic sx;
        sx = 1'b0;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_LW, OP_SW, OP_BEQ, OP_BNE: sx = 1'b1;
            OP_ANDI, OP_ORI, OP_XORI:     sx = (LOGIC_ZEXT == 0);
            default:                      sx = 1'b0;
        endcase
        return {{(XLEN-16){sx & imm16[15]}}, imm16};
    endfunction

    // JALR is an R-form function, so it already lands on rd.
    function automatic logic [4:0] dest_adr(input logic [5:0] op,
                                            input logic [4:0] rt,
                                            input logic [4:0] rd);
        if (op == OP_JAL)   return 5'd31;
        if (op == OP_RFORM) return rd;
        return rt;
    endfunction

    function automatic logic dest_we(input logic [5:0] op,
                                     input logic [5:0] func);
        logic we;
        we = 1'b0;
        case (op)
            OP_RFORM: we = !(func inside {FN_JR, FN_MTHI, FN_MTLO,
                                          FN_MULT, FN_DIV, FN_DIVU});
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: we = 1'b1;
            OP_LW, OP_JAL:                    we = 1'b1;
            default:                          we = 1'b0;
        endcase
        return we;
    endfunction

    logic [XLEN-1:0] rf_q [32];

    logic            out_valid_q,  out_valid_d;
    logic [31:0]     out_ins_q,    out_ins_d;
    logic [XLEN-1:0] out_rdata1_q, out_rdata1_d;
    logic [XLEN-1:0] out_rdata2_q, out_rdata2_d;
    logic [XLEN-1:0] out_imm_q,    out_imm_d;
    logic [4:0]      out_wadr_q,   out_wadr_d;
    logic            out_we_q,     out_we_d;

    logic [5:0]      op, func;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] rd1, rd2;
    logic            rf_we, stall, advance, in_ready_int, accept;
    logic [4:0]      hold_rs, hold_rt;
    logic            hit1, hit2;

    assign op   = bus.in_ins[31:26];
    assign rs   = bus.in_ins[25:21];
    assign rt   = bus.in_ins[20:16];
    assign rd   = bus.in_ins[15:11];
    assign func = bus.in_ins[5:0];

    assign rf_we = bus.wb_we && !zero_reg(bus.wb_adr);

    // A load still in the output slot cannot feed the next instruction.
    assign stall = out_valid_q && (out_ins_q[31:26] == OP_LW) &&
                   (out_wadr_q != 5'd0) &&
                   ((out_wadr_q == rs) || (out_wadr_q == rt));

    assign advance      = bus.out_ready || !out_valid_q;
    assign in_ready_int = advance && !stall && !bus.flush;
    assign accept       = bus.in_valid && in_ready_int;
    // Reset gating stays on the output only, so no flop sees RST as data.
    assign bus.in_ready = RST && in_ready_int;

    assign hold_rs = out_ins_q[25:21];
    assign hold_rt = out_ins_q[20:16];
    assign hit1    = bus.wb_we && (bus.wb_adr == hold_rs) && !zero_reg(hold_rs);
    assign hit2    = bus.wb_we && (bus.wb_adr == hold_rt) && !zero_reg(hold_rt);

    // Operand read with same-cycle write-back bypass.
    always_comb begin
        rd1 = rf_q[rs];
        rd2 = rf_q[rt];
        if (bus.wb_we && (bus.wb_adr == rs)) rd1 = bus.wb_data;
        if (bus.wb_we && (bus.wb_adr == rt)) rd2 = bus.wb_data;
        if (zero_reg(rs)) rd1 = '0;
        if (zero_reg(rt)) rd2 = '0;
    end

    // Output-slot next state: flush beats everything, then advance/load,
    // otherwise hold while refreshing operands from write-back.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_ins_d    = out_ins_q;
        out_rdata1_d = out_rdata1_q;
        out_rdata2_d = out_rdata2_q;
        out_imm_d    = out_imm_q;
        out_wadr_d   = out_wadr_q;
        out_we_d     = out_we_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (advance) begin
            if (accept) begin
                out_valid_d  = 1'b1;
                out_ins_d    = bus.in_ins;
                out_rdata1_d = rd1;
                out_rdata2_d = rd2;
                out_imm_d    = ext_imm(op, bus.in_ins[15:0]);
                out_wadr_d   = dest_adr(op, rt, rd);
                out_we_d     = dest_we(op, func);
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            if (hit1) out_rdata1_d = bus.wb_data;
            if (hit2) out_rdata2_d = bus.wb_data;
        end
    end

    // Output slot registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q  <= 1'b0;
            out_ins_q    <= '0;
            out_rdata1_q <= '0;
            out_rdata2_q <= '0;
            out_imm_q    <= '0;
            out_wadr_q   <= '0;
            out_we_q     <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ins_q    <= out_ins_d;
            out_rdata1_q <= out_rdata1_d;
            out_rdata2_q <= out_rdata2_d;
            out_imm_q    <= out_imm_d;
            out_wadr_q   <= out_wadr_d;
            out_we_q     <= out_we_d;
        end
    end

    // Register file write port.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[bus.wb_adr] <= bus.wb_data;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_ins    = out_ins_q;
    assign bus.out_rdata1 = out_rdata1_q;
    assign bus.out_rdata2 = out_rdata2_q;
    assign bus.out_imm    = out_imm_q;
    assign bus.out_wadr   = out_wadr_q;
    assign bus.out_we     = out_we_q;
endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: table of instructions with expected decode pushed to a
// scoreboard on acceptance and compared when EX takes the result; a second
// instance with LOGIC_ZEXT=0 runs in lockstep for the legacy immediates.
module tb_id_pipe;
    localparam int XLEN = 32;

    logic CLK;
    logic RST;

    id_pipe_if #(.XLEN(XLEN)) bus ();
    id_pipe_if #(.XLEN(XLEN)) bus_sx ();

    id_pipe #(.XLEN(XLEN), .ZERO_R0(1), .LOGIC_ZEXT(1)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );
    id_pipe #(.XLEN(XLEN), .ZERO_R0(1), .LOGIC_ZEXT(0)) dut_sx (
        .CLK(CLK), .RST(RST), .bus(bus_sx)
    );

    assign bus_sx.in_valid  = bus.in_valid;
    assign bus_sx.in_ins    = bus.in_ins;
    assign bus_sx.flush     = bus.flush;
    assign bus_sx.wb_we     = bus.wb_we;
    assign bus_sx.wb_adr    = bus.wb_adr;
    assign bus_sx.wb_data   = bus.wb_data;
    assign bus_sx.out_ready = bus.out_ready;

    typedef struct {
        logic [31:0] ins;
        logic        wb_en;
        logic [4:0]  wb_adr;
        logic [31:0] wb_data;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] imm_sx;
        logic [4:0]  wadr;
        logic        we;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[14];
    vec_t mon_e;
    int   total = 0;
    int   bad   = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] ins, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm,
                                input logic [31:0] imm_sx, input logic [4:0] wadr,
                                input logic we);
        vec_t v;
        v.ins = ins; v.wb_en = 1'b0; v.wb_adr = 5'd0; v.wb_data = 32'd0;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.imm_sx = imm_sx;
        v.wadr = wadr; v.we = we;
        return v;
    endfunction

    // Offer one instruction (with optional write-back alongside) until taken.
    task automatic send(input vec_t v);
        int  waited;
        bit  done;
        bus.wb_we    = v.wb_en;
        bus.wb_adr   = v.wb_adr;
        bus.wb_data  = v.wb_data;
        bus.in_ins   = v.ins;
        bus.in_valid = 1'b1;
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge CLK);
            if (bus.in_ready) begin
                sb.push_back(v);
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 20) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout ins=%h: in_ready=0 want 1", v.ins);
                    done = 1'b1;
                end
            end
            @(posedge CLK);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.wb_we    = 1'b0;
    endtask

    // Scoreboard check whenever EX takes a result.
    always @(negedge CLK) begin
        if (RST && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: out_ins=%h with empty scoreboard", bus.out_ins);
            end else begin
                mon_e = sb.pop_front();
                chk("mon_ins",    bus.out_ins,    mon_e.ins);
                chk("mon_rdata1", bus.out_rdata1, mon_e.rd1);
                chk("mon_rdata2", bus.out_rdata2, mon_e.rd2);
                chk("mon_imm",    bus.out_imm,    mon_e.imm);
                chk("mon_imm_sx", bus_sx.out_imm, mon_e.imm_sx);
                chk("mon_wadr",   bus.out_wadr,   mon_e.wadr);
                chk("mon_we",     bus.out_we,     mon_e.we);
            end
        end
    end

    initial begin
        //           ins           wb  adr    data          rd1           rd2           imm           imm_sx        wadr  we
        tbl[0]  = '{32'h2001FFFF, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  1}; // ADDI r1,r0,-1
        tbl[1]  = '{32'h34028000, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h00008000, 32'hFFFF8000, 5'd2,  1}; // ORI r2,r0,0x8000
        tbl[2]  = '{32'h00632020, 1, 5'd3,  32'h12345678, 32'h12345678, 32'h12345678, 32'h00002020, 32'h00002020, 5'd4,  1}; // ADD r4,r3,r3 + wb r3
        tbl[3]  = '{32'h0C000010, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h00000010, 32'h00000010, 5'd31, 1}; // JAL
        tbl[4]  = '{32'h00600008, 0, 5'd0,  32'h0,        32'h12345678, 32'h0,        32'h00000008, 32'h00000008, 5'd0,  0}; // JR r3
        tbl[5]  = '{32'hAC23FFFC, 0, 5'd0,  32'h0,        32'h0,        32'h12345678, 32'hFFFFFFFC, 32'hFFFFFFFC, 5'd3,  0}; // SW r3,-4(r1)
        tbl[6]  = '{32'h3069F0F0, 0, 5'd0,  32'h0,        32'h12345678, 32'h0,        32'h0000F0F0, 32'hFFFFF0F0, 5'd9,  1}; // ANDI r9,r3
        tbl[7]  = '{32'h3C0A1234, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h00001234, 32'h00001234, 5'd10, 1}; // LUI r10
        tbl[8]  = '{32'h1060FFFF, 0, 5'd0,  32'h0,        32'h12345678, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  0}; // BEQ r3,r0
        tbl[9]  = '{32'h00630018, 0, 5'd0,  32'h0,        32'h12345678, 32'h12345678, 32'h00000018, 32'h00000018, 5'd0,  0}; // MULT r3,r3
        tbl[10] = '{32'h0060F809, 0, 5'd0,  32'h0,        32'h12345678, 32'h0,        32'h0000F809, 32'h0000F809, 5'd31, 1}; // JALR r31,r3
        tbl[11] = '{32'h00006820, 1, 5'd0,  32'h00000005, 32'h0,        32'h0,        32'h00006820, 32'h00006820, 5'd13, 1}; // ADD r13,r0,r0 + wb r0=5
        tbl[12] = '{32'h00037020, 0, 5'd0,  32'h0,        32'h0,        32'h12345678, 32'h00007020, 32'h00007020, 5'd14, 1}; // ADD r14,r0,r3
        tbl[13] = '{32'h386F8001, 1, 5'd3,  32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        32'h00008001, 32'hFFFF8001, 5'd15, 1}; // XORI r15,r3 + wb r3

        RST           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ins    = 32'd0;
        bus.flush     = 1'b0;
        bus.wb_we     = 1'b0;
        bus.wb_adr    = 5'd0;
        bus.wb_data   = 32'd0;
        bus.out_ready = 1'b1;

        // Reset state.
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready,  0);
        chk("rst_out_ins",   bus.out_ins,   0);
        chk("rst_out_imm",   bus.out_imm,   0);
        chk("rst_out_we",    bus.out_we,    0);
        #6 RST = 1'b1;
        @(posedge CLK);
        #1;

        // Streamed decode vectors.
        for (int i = 0; i < 14; i++) send(tbl[i]);

        // Load-use: LW r5,0(r0) then ADD r6,r5,r5.
        bus.in_ins   = 32'h8C050000;
        bus.in_valid = 1'b1;
        @(negedge CLK);
        chk("lu_lw_ready", bus.in_ready, 1);
        sb.push_back(mk(32'h8C050000, 0, 0, 32'h0, 32'h0, 5'd5, 1'b1));
        @(posedge CLK); #1;
        bus.in_ins = 32'h00A53020;
        @(negedge CLK);
        chk("lu_stall_ready", bus.in_ready, 0);
        chk("lu_lw_valid",    bus.out_valid, 1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("lu_bubble",      bus.out_valid, 0);
        chk("lu_retry_ready", bus.in_ready, 1);
        sb.push_back(mk(32'h00A53020, 0, 0, 32'h00003020, 32'h00003020, 5'd6, 1'b1));
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("lu_add_valid", bus.out_valid, 1);
        chk("lu_add_ins",   bus.out_ins, 32'h00A53020);
        @(posedge CLK); #1;

        // Hold ADD r7,r8,r0 while r8 is written back.
        bus.out_ready = 1'b0;
        bus.in_ins    = 32'h01003820;
        bus.in_valid  = 1'b1;
        @(negedge CLK);
        chk("hold_accept_ready", bus.in_ready, 1);
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        bus.wb_we    = 1'b1;
        bus.wb_adr   = 5'd8;
        bus.wb_data  = 32'h000000AA;
        @(negedge CLK);
        chk("hold_rdata1_before", bus.out_rdata1, 32'h0);
        @(posedge CLK); #1;
        bus.wb_we = 1'b0;
        @(negedge CLK);
        chk("hold_valid",    bus.out_valid, 1);
        chk("hold_refresh",  bus.out_rdata1, 32'h000000AA);
        chk("hold_in_ready", bus.in_ready, 0);
        sb.push_back(mk(32'h01003820, 32'h000000AA, 0, 32'h00003820, 32'h00003820, 5'd7, 1'b1));
        @(posedge CLK); #1;
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;

        // Flush with a held instruction and a new one on offer.
        bus.out_ready = 1'b0;
        bus.in_ins    = 32'h240C0005;
        bus.in_valid  = 1'b1;
        @(posedge CLK); #1;
        bus.in_ins = 32'h34028000;
        bus.flush  = 1'b1;
        @(negedge CLK);
        chk("flush_in_ready", bus.in_ready, 0);
        chk("flush_held",     bus.out_valid, 1);
        @(posedge CLK); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge CLK);
        chk("flush_valid", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;

        // Reset while an instruction is held.
        bus.out_ready = 1'b0;
        bus.in_ins    = 32'h0C000010;
        bus.in_valid  = 1'b1;
        @(posedge CLK); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        RST = 1'b0;
        #1;
        chk("mid_rst_valid",    bus.out_valid, 0);
        chk("mid_rst_ins",      bus.out_ins, 0);
        chk("mid_rst_wadr",     bus.out_wadr, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        #3 RST = 1'b1;
        @(posedge CLK); #1;
        send(mk(32'h00632020, 0, 0, 32'h00002020, 32'h00002020, 5'd4, 1'b1));
        @(posedge CLK); #1;
        @(posedge CLK); #1;

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
